// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: frame-synchronous ball game sequencer.
// Detects the start of vertical blanking from the VGA counters. Once per
// SPEED_DIV frames it advances the ball, resolves wall and paddle collisions
// and updates the score or miss flag. Outputs change only in COMMIT/MISS,
// which are a few cycles after the blanking edge, so active video never sees
// a mid-frame position change.
// Ports:
//   clk, rst_n        pixel clock, async active-low reset
//   Hcnt, Vcnt        VGA pixel/line counters (only the tick compare uses them)
//   paddle_x          paddle left edge, sampled while resolving collisions
//   start             level; launches play from IDLE
//   ball_x, ball_y    ball top-left corner
//   score             paddle hits, wraps modulo 256
//   miss              set by a miss, cleared by the next accepted start
//   busy              high whenever the sequencer is not in IDLE
module ball_motion_ctrl #(
  parameter int PAL       = 640,
  parameter int LAF       = 480,
  parameter int BALL_SIZE = 8,
  parameter int STEP      = 4,
  parameter int PADDLE_Y  = 464,
  parameter int PADDLE_W  = 64,
  parameter int SPEED_DIV = 1,
  parameter int INIT_Y    = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] Hcnt,
  input  logic [9:0] Vcnt,
  input  logic [9:0] paddle_x,
  input  logic       start,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [7:0] score,
  output logic       miss,
  output logic       busy
);

  localparam logic [9:0] X0 = 10'((PAL - BALL_SIZE) / 2);
  localparam logic [9:0] Y0 = 10'(INIT_Y);
  localparam logic [3:0] DIV_LAST = 4'(SPEED_DIV - 1);
  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic signed [11:0] XMAX_S  = 12'(PAL - BALL_SIZE);
  localparam logic signed [11:0] BALL_S  = 12'(BALL_SIZE);
  localparam logic signed [11:0] PADY_S  = 12'(PADDLE_Y);
  localparam logic signed [11:0] PADW_S  = 12'(PADDLE_W);
  localparam logic [9:0] YREST = 10'(PADDLE_Y - BALL_SIZE);

  typedef enum logic [2:0] {
    IDLE, WAIT_FRAME, STEP_ST, COLLIDE, COMMIT, MISS_ST
  } state_t;

  state_t st, st_nx;

  logic              frame_tick;
  logic [3:0]        div;
  logic              dir_x, dir_y;   // 1 = increasing coordinate
  logic signed [10:0] nx, ny;        // candidate position, no 10-bit wrap
  logic [9:0]        cx, cy;         // resolved position awaiting commit
  logic              cdx, cdy, chit;

  // collision resolution (combinational, consumed in COLLIDE)
  logic signed [11:0] nxe, nye, pxe;
  logic [9:0]         rx, ry;
  logic               rdx, rdy, rhit, rmiss;

  always_comb begin
    nxe   = {nx[10], nx};
    nye   = {ny[10], ny};
    pxe   = {2'b00, paddle_x};
    rx    = nx[9:0];
    ry    = ny[9:0];
    rdx   = dir_x;
    rdy   = dir_y;
    rhit  = 1'b0;
    rmiss = 1'b0;
    if (nxe > XMAX_S) begin
      rx  = XMAX_S[9:0];
      rdx = 1'b0;
    end else if (nxe < 0) begin
      rx  = '0;
      rdx = 1'b1;
    end
    if (nye < 0) begin
      ry  = '0;
      rdy = 1'b1;
    end else if (dir_y && (nye + BALL_S > PADY_S)) begin
      // overlap test uses the already-moved x candidate
      if ((nxe + BALL_S > pxe) && (nxe < pxe + PADW_S)) begin
        ry   = YREST;
        rdy  = 1'b0;
        rhit = 1'b1;
      end else begin
        rmiss = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    case (st)
      IDLE:       if (start) st_nx = WAIT_FRAME;
      WAIT_FRAME: if (frame_tick && div == DIV_LAST) st_nx = STEP_ST;
      STEP_ST:    st_nx = COLLIDE;
      COLLIDE:    st_nx = rmiss ? MISS_ST : COMMIT;
      COMMIT:     st_nx = WAIT_FRAME;
      MISS_ST:    st_nx = IDLE;
      default:    st_nx = IDLE;
    endcase
  end

  assign busy = (st != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick <= 1'b0;
      div        <= '0;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      nx         <= '0;
      ny         <= '0;
      cx         <= X0;
      cy         <= Y0;
      cdx        <= 1'b1;
      cdy        <= 1'b1;
      chit       <= 1'b0;
      ball_x     <= X0;
      ball_y     <= Y0;
      score      <= '0;
      miss       <= 1'b0;
    end else begin
      // one pulse per frame at the first blanking line
      frame_tick <= (Hcnt == 10'd0) && (Vcnt == 10'(LAF));
      case (st)
        IDLE: if (start) miss <= 1'b0;
        WAIT_FRAME:
          if (frame_tick) div <= (div == DIV_LAST) ? 4'd0 : div + 4'd1;
        STEP_ST: begin
          nx <= $signed({1'b0, ball_x}) + (dir_x ? STEP_S : -STEP_S);
          ny <= $signed({1'b0, ball_y}) + (dir_y ? STEP_S : -STEP_S);
        end
        COLLIDE: begin
          cx   <= rx;
          cy   <= ry;
          cdx  <= rdx;
          cdy  <= rdy;
          chit <= rhit;
        end
        COMMIT: begin
          ball_x <= cx;
          ball_y <= cy;
          dir_x  <= cdx;
          dir_y  <= cdy;
          if (chit) score <= score + 8'd1;
        end
        MISS_ST: begin
          ball_x <= X0;
          ball_y <= Y0;
          dir_x  <= 1'b1;
          dir_y  <= 1'b1;
          miss   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl. A compressed frame (2 pixels x lines
// 479..481) keeps runs short; only the Hcnt==0/Vcnt==480 point matters.
// dut  : default parameters, full trajectory through walls, paddle and miss.
// dut2 : SPEED_DIV=3, shallow playfield and a full-width paddle so score wraps.
module tb_ball_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] Hcnt = 10'd0, Vcnt = 10'd479;
  logic [9:0] paddle_x = 10'd560, paddle_x2 = 10'd0;
  logic       start = 1'b0, start2 = 1'b0;
  logic [9:0] ball_x, ball_y, ball_x2, ball_y2;
  logic [7:0] score, score2;
  logic       miss, busy, miss2, busy2;

  int n_chk = 0, n_fail = 0, upd = 0;

  always #5 clk = ~clk;

  ball_motion_ctrl dut (
    .clk(clk), .rst_n(rst_n), .Hcnt(Hcnt), .Vcnt(Vcnt), .paddle_x(paddle_x),
    .start(start), .ball_x(ball_x), .ball_y(ball_y), .score(score),
    .miss(miss), .busy(busy)
  );

  ball_motion_ctrl #(.SPEED_DIV(3), .PADDLE_Y(16), .INIT_Y(8), .PADDLE_W(1023)) dut2 (
    .clk(clk), .rst_n(rst_n), .Hcnt(Hcnt), .Vcnt(Vcnt), .paddle_x(paddle_x2),
    .start(start2), .ball_x(ball_x2), .ball_y(ball_y2), .score(score2),
    .miss(miss2), .busy(busy2)
  );

  // compressed VGA counters, changed on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (Hcnt == 10'd1) begin
        Hcnt = 10'd0;
        Vcnt = (Vcnt == 10'd481) ? 10'd479 : Vcnt + 10'd1;
      end else begin
        Hcnt = Hcnt + 10'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_ball(input string tag, input int x, input int y);
    chk({tag, ".x"}, 32'(ball_x), 32'(x));
    chk({tag, ".y"}, 32'(ball_y), 32'(y));
  endtask

  // returns on the rising edge that samples Hcnt==0 && Vcnt==480
  task automatic wait_cmp();
    int n = 0;
    @(posedge clk);
    while (!(Hcnt == 10'd0 && Vcnt == 10'd480) && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20) chk("cmp_timeout", 32'd1, 32'd0);
  endtask

  // let the main DUT perform updates until 'target' updates have landed
  task automatic run_to(input int target);
    while (upd < target) begin
      wait_cmp();
      repeat (4) @(posedge clk);
      upd++;
    end
    #1;
  endtask

  task automatic pulse_start_off_tick(input bit which);
    wait_cmp();
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (which) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start2 = 1'b0;
  endtask

  initial begin
    int exp_sc[6] = '{0, 0, 1, 1, 1, 1};
    int exp_y2[6] = '{8, 8, 8, 8, 8, 4};
    int exp_x2[6] = '{316, 316, 320, 320, 320, 324};
    int n;

    // reset held while counters run mid-frame
    repeat (7) @(negedge clk);
    chk_ball("rst_low", 316, 100);
    chk("rst_low.score", 32'(score), 0);
    chk("rst_low.miss", 32'(miss), 0);
    chk("rst_low.busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_ball("rst_rel", 316, 100);
    chk("rst_rel.busy", 32'(busy), 0);

    // ticks in IDLE do nothing
    wait_cmp();
    repeat (5) @(posedge clk);
    #1;
    chk_ball("idle_tick", 316, 100);
    chk("idle_tick.busy", 32'(busy), 0);

    // launch, first update latency
    pulse_start_off_tick(1'b0);
    chk("start.busy", 32'(busy), 1);
    wait_cmp();
    repeat (3) @(posedge clk);
    #1;
    chk_ball("lat_c3", 316, 100);
    @(posedge clk);
    #1;
    chk_ball("lat_c4", 320, 104);
    upd = 1;
    // start while busy is ignored
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_to(2);
    chk_ball("upd2", 324, 108);
    chk("upd2.busy", 32'(busy), 1);

    // right wall
    run_to(79); chk_ball("rwall79", 632, 416);
    run_to(80); chk_ball("rwall80", 632, 420);
    run_to(81); chk_ball("rwall81", 628, 424);

    // paddle hit at paddle_x=560
    run_to(89); chk_ball("pre_hit", 596, 456);
    run_to(90); chk_ball("hit", 592, 456);
    chk("hit.score", 32'(score), 1);
    run_to(91); chk_ball("after_hit", 588, 452);
    paddle_x = 10'd0;

    // top wall
    run_to(205); chk_ball("top205", 132, 0);
    run_to(206); chk_ball("top206", 128, 4);

    // left wall
    run_to(239); chk_ball("left239", 0, 136);
    run_to(240); chk_ball("left240", 4, 140);

    // miss at the bottom with the paddle away
    run_to(319); chk_ball("pre_miss", 320, 456);
    run_to(320);
    chk_ball("miss", 316, 100);
    chk("miss.flag", 32'(miss), 1);
    chk("miss.busy", 32'(busy), 0);
    chk("miss.score", 32'(score), 1);

    // start coinciding with the tick: first update one frame later
    wait_cmp();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_ball("st_tick_same", 316, 100);
    chk("st_tick_same.miss", 32'(miss), 0);
    chk("st_tick_same.busy", 32'(busy), 1);
    wait_cmp();
    repeat (4) @(posedge clk);
    #1;
    chk_ball("st_tick_next", 320, 104);

    // reset pulse while COLLIDE is in flight
    wait_cmp();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_ball("midrst_low", 316, 100);
    chk("midrst_low.score", 32'(score), 0);
    chk("midrst_low.busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_ball("midrst_after", 316, 100);
    chk("midrst_after.busy", 32'(busy), 0);

    // divider: one update every third frame
    pulse_start_off_tick(1'b1);
    for (int f = 0; f < 6; f++) begin
      wait_cmp();
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("div_f%0d.score", f + 1), 32'(score2), 32'(exp_sc[f]));
      chk($sformatf("div_f%0d.y", f + 1), 32'(ball_y2), 32'(exp_y2[f]));
      chk($sformatf("div_f%0d.x", f + 1), 32'(ball_x2), 32'(exp_x2[f]));
    end

    // score wrap 255 -> 0
    n = 0;
    while (score2 != 8'd255 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk("wrap.reach255", 32'(score2), 255);
    chk("wrap.y255", 32'(ball_y2), 8);
    n = 0;
    while (score2 == 8'd255 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("wrap.score0", 32'(score2), 0);
    chk("wrap.y0", 32'(ball_y2), 8);
    chk("wrap.miss", 32'(miss2), 0);
    chk("wrap.busy", 32'(busy2), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
